// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
//   Stall/flush controller for the 5-stage MIPS pipeline, placed beside ID.
//   Detects load-use and branch-operand data hazards ($0 never hazards,
//   rt only counted for instructions that read it), and freezes the whole
//   pipeline while a multi-cycle data-memory access is outstanding.
//
//   Inputs : op/rs/rt of the ID instruction; destination, write-enable and
//            writeback-select of the EXE and MEM instructions; mem_access
//            and the dmem_ready handshake.
//   Outputs: pc_stall, if_id_stall, id_exe_flush, id_exe_stall,
//            exe_mem_stall, mem_wb_bubble (combinational);
//            hz_state (0 RUN / 1 MEMWAIT), sticky hz_timeout and the
//            stat_stall/stat_flush/stat_wait counters (registered).
//
//   Optional: define HAZARD_STATS_EN to build the saturating statistics
//   counters; otherwise the stat_* ports are tied to zero.
module hazard_stall_ctrl #(
  parameter int unsigned             REG_AW   = 5,
  parameter int unsigned             OP_W     = 6,
  parameter int unsigned             SEL_W    = 2,
  parameter logic [SEL_W-1:0]        LOAD_SEL = 2'b01,
  parameter logic [OP_W-1:0]         BEQ_OP   = 6'b000100,
  parameter logic [OP_W-1:0]         BNE_OP   = 6'b000101,
  parameter logic [OP_W-1:0]         SW_OP    = 6'b101011,
  parameter int unsigned             MAX_WAIT = 15,
  parameter int unsigned             CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [OP_W-1:0]   op,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  input  logic [REG_AW-1:0] exe_num_write,
  input  logic              exe_reg_write,
  input  logic [SEL_W-1:0]  exe_s_data_write,
  input  logic [REG_AW-1:0] mem_num_write,
  input  logic              mem_reg_write,
  input  logic [SEL_W-1:0]  mem_s_data_write,
  input  logic              mem_access,
  input  logic              dmem_ready,
  output logic              pc_stall,
  output logic              if_id_stall,
  output logic              id_exe_flush,
  output logic              id_exe_stall,
  output logic              exe_mem_stall,
  output logic              mem_wb_bubble,
  output logic              hz_state,
  output logic              hz_timeout,
  output logic [CNT_W-1:0]  stat_stall,
  output logic [CNT_W-1:0]  stat_flush,
  output logic [CNT_W-1:0]  stat_wait
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] MAX_CNT  = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] LAST_CNT = WAIT_W'(MAX_WAIT - 1);

  typedef enum logic {
    RUN     = 1'b0,
    MEMWAIT = 1'b1
  } hz_state_t;

  hz_state_t         state;
  logic [WAIT_W-1:0] wait_cnt;

  logic use_rt, br, hit_e, hit_m;
  logic load_use, br_exe, br_mem, dhaz, freeze;

  // Hazard detection
  always_comb begin
    use_rt   = (op == '0) || (op == BEQ_OP) || (op == BNE_OP) || (op == SW_OP);
    br       = (op == BEQ_OP) || (op == BNE_OP);
    hit_e    = exe_reg_write && (exe_num_write != '0) &&
               ((exe_num_write == rs) || (use_rt && (exe_num_write == rt)));
    hit_m    = mem_reg_write && (mem_num_write != '0) &&
               ((mem_num_write == rs) || (use_rt && (mem_num_write == rt)));
    load_use = hit_e && (exe_s_data_write == LOAD_SEL);
    br_exe   = br && hit_e;
    br_mem   = br && hit_m && (mem_s_data_write == LOAD_SEL);
    dhaz     = load_use || br_exe || br_mem;
    freeze   = mem_access && !dmem_ready;
  end

  // Pipeline controls. Gated by rst_n so an asserted reset silences them
  // at once, even mid-freeze. Freeze wins over dhaz; a data hazard still
  // present when the freeze releases is handled in that release cycle.
  always_comb begin
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    id_exe_flush  = 1'b0;
    id_exe_stall  = 1'b0;
    exe_mem_stall = 1'b0;
    mem_wb_bubble = 1'b0;
    if (rst_n) begin
      if (freeze) begin
        pc_stall      = 1'b1;
        if_id_stall   = 1'b1;
        id_exe_stall  = 1'b1;
        exe_mem_stall = 1'b1;
        mem_wb_bubble = 1'b1;
      end else if (dhaz) begin
        pc_stall      = 1'b1;
        if_id_stall   = 1'b1;
        id_exe_flush  = 1'b1;
      end
    end
  end

  // Freeze FSM with saturating wait counter and sticky timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      wait_cnt   <= '0;
      hz_timeout <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          wait_cnt <= '0;
          if (freeze) state <= MEMWAIT;
        end
        MEMWAIT: begin
          if (wait_cnt != MAX_CNT) wait_cnt <= wait_cnt + 1'b1;
          if (wait_cnt == LAST_CNT) hz_timeout <= 1'b1;
          if (!freeze) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  assign hz_state = (state == MEMWAIT);

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_stall <= '0;
      stat_flush <= '0;
      stat_wait  <= '0;
    end else begin
      if (dhaz && (stat_stall != '1))         stat_stall <= stat_stall + 1'b1;
      if (id_exe_flush && (stat_flush != '1)) stat_flush <= stat_flush + 1'b1;
      if (freeze && (stat_wait != '1))        stat_wait  <= stat_wait + 1'b1;
    end
  end
`else
  assign stat_stall = '0;
  assign stat_flush = '0;
  assign stat_wait  = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: a driver applies one stimulus per
// cycle and pushes the reference model's expected outputs; a monitor pops
// and compares on the falling edge.
module tb_hazard_stall_ctrl;

  localparam logic [1:0] LOAD = 2'b01;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] BNE  = 6'b000101;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam int         MAXW = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  op;
  logic [4:0]  rs, rt, exe_num_write, mem_num_write;
  logic        exe_reg_write, mem_reg_write, mem_access, dmem_ready;
  logic [1:0]  exe_s_data_write, mem_s_data_write;
  logic        pc_stall, if_id_stall, id_exe_flush, id_exe_stall;
  logic        exe_mem_stall, mem_wb_bubble, hz_state, hz_timeout;
  logic [15:0] stat_stall, stat_flush, stat_wait;

  hazard_stall_ctrl #(
    .REG_AW(5), .OP_W(6), .SEL_W(2), .LOAD_SEL(LOAD),
    .BEQ_OP(BEQ), .BNE_OP(BNE), .SW_OP(SW), .MAX_WAIT(MAXW), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .rs(rs), .rt(rt),
    .exe_num_write(exe_num_write), .exe_reg_write(exe_reg_write),
    .exe_s_data_write(exe_s_data_write),
    .mem_num_write(mem_num_write), .mem_reg_write(mem_reg_write),
    .mem_s_data_write(mem_s_data_write),
    .mem_access(mem_access), .dmem_ready(dmem_ready),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_exe_flush(id_exe_flush),
    .id_exe_stall(id_exe_stall), .exe_mem_stall(exe_mem_stall),
    .mem_wb_bubble(mem_wb_bubble), .hz_state(hz_state), .hz_timeout(hz_timeout),
    .stat_stall(stat_stall), .stat_flush(stat_flush), .stat_wait(stat_wait)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rn;
    logic [5:0] op;
    logic [4:0] rs, rt, en;
    logic       ew;
    logic [1:0] es;
    logic [4:0] mn;
    logic       mw;
    logic [1:0] ms;
    logic       ma, dr;
  } stim_t;

  typedef struct packed {
    logic [7:0]  ctl;  // pc, if_id, flush, id_exe_stall, exe_mem_stall, bubble, state, timeout
    logic [15:0] ss, sf, sw;
    logic [3:0]  wc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model state: "previous cycle was frozen", length of the
  // current wait episode (capped), sticky timeout flag, event tallies.
  bit m_wait;
  int m_wc, m_ss, m_sf, m_sw;
  bit m_to;

  function automatic bit reads_reg(input logic [4:0] r, input stim_t s);
    bit rt_used;
    rt_used = (s.op == 6'd0) || (s.op == BEQ) || (s.op == BNE) || (s.op == SW);
    return (r != 5'd0) && ((r == s.rs) || (rt_used && (r == s.rt)));
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.rn = 1'b1;
    s.op = ADDI;
    s.dr = 1'b1;
    return s;
  endfunction

  task automatic step(input stim_t s);
    exp_t e;
    bit is_br, hz_e, hz_m, dhaz, frz, flush;
    @(posedge clk);
    #1;
    rst_n = s.rn; op = s.op; rs = s.rs; rt = s.rt;
    exe_num_write = s.en; exe_reg_write = s.ew; exe_s_data_write = s.es;
    mem_num_write = s.mn; mem_reg_write = s.mw; mem_s_data_write = s.ms;
    mem_access = s.ma; dmem_ready = s.dr;
    if (!s.rn) begin
      m_wait = 0; m_wc = 0; m_to = 0; m_ss = 0; m_sf = 0; m_sw = 0;
    end
    is_br = (s.op == BEQ) || (s.op == BNE);
    hz_e  = s.ew && reads_reg(s.en, s);
    hz_m  = s.mw && reads_reg(s.mn, s);
    dhaz  = (hz_e && ((s.es == LOAD) || is_br)) || (hz_m && is_br && (s.ms == LOAD));
    frz   = s.ma && !s.dr;
    flush = dhaz && !frz;
    e = '0;
    if (s.rn) begin
      if (frz)       e.ctl[7:2] = 6'b110111;
      else if (dhaz) e.ctl[7:2] = 6'b111000;
    end
    e.ctl[1] = m_wait;
    e.ctl[0] = m_to;
`ifdef HAZARD_STATS_EN
    e.ss = 16'(m_ss); e.sf = 16'(m_sf); e.sw = 16'(m_sw);
`endif
    e.wc = 4'(m_wc);
    exp_q.push_back(e);
    if (s.rn) begin
      m_wc = m_wait ? ((m_wc + 1 > MAXW) ? MAXW : m_wc + 1) : 0;
      if (m_wc == MAXW) m_to = 1;
      m_wait = frz;
      if (dhaz  && m_ss < 65535) m_ss++;
      if (flush && m_sf < 65535) m_sf++;
      if (frz   && m_sw < 65535) m_sw++;
    end
  endtask

  // Monitor
  initial begin
    exp_t e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a.ctl = {pc_stall, if_id_stall, id_exe_flush, id_exe_stall,
                 exe_mem_stall, mem_wb_bubble, hz_state, hz_timeout};
        a.ss = stat_stall; a.sf = stat_flush; a.sw = stat_wait;
        a.wc = dut.wait_cnt;
        n_vec++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL vec%0d ctl act=%b exp=%b stats act=%0d/%0d/%0d exp=%0d/%0d/%0d wait_cnt act=%0d exp=%0d",
                   n_vec, a.ctl, e.ctl, a.ss, a.sf, a.sw, e.ss, e.sf, e.sw, a.wc, e.wc);
        end
      end
    end
  end

  // Driver
  initial begin
    stim_t s;
    logic [5:0] ops [6];
    ops[0] = 6'd0; ops[1] = BEQ; ops[2] = BNE; ops[3] = SW; ops[4] = LW; ops[5] = ADDI;
    rst_n = 1'b0; op = '0; rs = '0; rt = '0; exe_num_write = '0; exe_reg_write = 1'b0;
    exe_s_data_write = '0; mem_num_write = '0; mem_reg_write = 1'b0;
    mem_s_data_write = '0; mem_access = 1'b0; dmem_ready = 1'b1;
    m_wait = 0; m_wc = 0; m_to = 0; m_ss = 0; m_sf = 0; m_sw = 0;

    s = idle(); s.rn = 1'b0;
    step(s); step(s);
    s = idle(); step(s);

    // Load-use on rs, then the bubble arrives
    s = idle(); s.op = 6'd0; s.rs = 5'd8; s.rt = 5'd9;
    s.en = 5'd8; s.ew = 1'b1; s.es = LOAD; step(s);
    s.ew = 1'b0; s.en = 5'd0; s.es = 2'b00; step(s);

    // $0 never hazards; I-type rt not read
    s = idle(); s.op = 6'd0; s.rs = 5'd0; s.en = 5'd0; s.ew = 1'b1; s.es = LOAD; step(s);
    s = idle(); s.op = ADDI; s.rs = 5'd1; s.rt = 5'd8; s.en = 5'd8; s.ew = 1'b1; s.es = LOAD; step(s);

    // Branch operand from EXE ALU, then MEM load, then MEM ALU
    s = idle(); s.op = BEQ; s.rs = 5'd3; s.rt = 5'd4; s.en = 5'd4; s.ew = 1'b1; step(s);
    s.ew = 1'b0; s.en = 5'd0; s.mn = 5'd4; s.mw = 1'b1; s.ms = LOAD; step(s);
    s.ms = 2'b00; step(s);

    // Short freeze: 3 wait cycles then ready
    s = idle(); s.ma = 1'b1; s.dr = 1'b0;
    repeat (3) step(s);
    s.dr = 1'b1; step(s);
    s = idle(); step(s); step(s);

    // Long freeze to timeout, timeout sticks until reset
    s = idle(); s.ma = 1'b1; s.dr = 1'b0;
    repeat (20) step(s);
    s.dr = 1'b1; step(s);
    s = idle(); repeat (3) step(s);
    s.rn = 1'b0; step(s);
    s = idle(); step(s);

    // Freeze concurrent with load-use, hazard handled on release
    s = idle(); s.op = 6'd0; s.rs = 5'd5; s.en = 5'd5; s.ew = 1'b1; s.es = LOAD;
    s.ma = 1'b1; s.dr = 1'b0; step(s); step(s);
    s.dr = 1'b1; step(s);
    s.ma = 1'b0; s.ew = 1'b0; step(s);

    // Reset mid-freeze
    s = idle(); s.ma = 1'b1; s.dr = 1'b0; step(s); step(s);
    s.rn = 1'b0; step(s);
    s = idle(); step(s);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      s.rn = ($urandom_range(0, 149) != 0);
      s.op = ops[$urandom_range(0, 5)];
      s.rs = 5'($urandom_range(0, 3));
      s.rt = 5'($urandom_range(0, 3));
      s.en = 5'($urandom_range(0, 3));
      s.ew = 1'($urandom_range(0, 1));
      s.es = 2'($urandom_range(0, 3));
      s.mn = 5'($urandom_range(0, 3));
      s.mw = 1'($urandom_range(0, 1));
      s.ms = 2'($urandom_range(0, 3));
      s.ma = 1'($urandom_range(0, 1));
      s.dr = ($urandom_range(0, 4) == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
      step(s);
    end

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
